// File: rtl/axil_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axil_pkg                                                  |
// | Brief    : AXI-Lite response codes and master FSM state encoding     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package axil_pkg;

   localparam logic [1:0] C_OKAY    = 2'b00;
   localparam logic [1:0] C_EX_OKAY = 2'b01;
   localparam logic [1:0] C_SLV_ERR = 2'b10;
   localparam logic [1:0] C_DEC_ERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } axil_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axil_master                                               |
// | Brief    : single-outstanding AXI4-Lite initiator, command/response  |
// |            front end; watchdog enabled by AXIL_MASTER_TIMEOUT_EN     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module axil_master
   import axil_pkg::*;
#(
   parameter int P_ADDR_WIDTH     = 11,
   parameter int P_DATA_WIDTH     = 32,
   parameter int P_TIMEOUT_CYCLES = 1024
) (
   input  logic                        m_axi_aclk,
   input  logic                        m_axi_areset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [P_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [P_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [P_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_write,
   output logic [P_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        rsp_timeout,
   output logic [P_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [P_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [P_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   output logic [P_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   input  logic [P_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready
);

   localparam int C_STRB_W = P_DATA_WIDTH / 8;

   if ((P_DATA_WIDTH != 32 && P_DATA_WIDTH != 64) || P_TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("axil_master: unsupported parameter set");
   end

   axil_mst_state_t state_q, state_d;

   logic                      cmd_ready_q,   cmd_ready_d;
   logic [P_ADDR_WIDTH-1:0]   awaddr_q,      awaddr_d;
   logic                      awvalid_q,     awvalid_d;
   logic [P_DATA_WIDTH-1:0]   wdata_q,       wdata_d;
   logic [C_STRB_W-1:0]       wstrb_q,       wstrb_d;
   logic                      wvalid_q,      wvalid_d;
   logic                      bready_q,      bready_d;
   logic [P_ADDR_WIDTH-1:0]   araddr_q,      araddr_d;
   logic                      arvalid_q,     arvalid_d;
   logic                      rready_q,      rready_d;
   logic                      rsp_valid_q,   rsp_valid_d;
   logic                      rsp_write_q,   rsp_write_d;
   logic [P_DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
   logic [1:0]                rsp_resp_q,    rsp_resp_d;
   logic                      rsp_timeout_q, rsp_timeout_d;

   logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
   logic w_wr_done, w_expire;

   assign w_accept  = cmd_valid & cmd_ready_q;
   assign w_aw_hs   = awvalid_q & m_axi_awready;
   assign w_w_hs    = wvalid_q & m_axi_wready;
   assign w_b_hs    = bready_q & m_axi_bvalid;
   assign w_ar_hs   = arvalid_q & m_axi_arready;
   assign w_r_hs    = rready_q & m_axi_rvalid;
   assign w_rsp_hs  = rsp_valid_q & rsp_ready;
   // Each write channel is finished once its valid is low or handshaking now.
   assign w_wr_done = (~awvalid_q | m_axi_awready) & (~wvalid_q | m_axi_wready);

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int C_CNT_W = $clog2(P_TIMEOUT_CYCLES) + 1;

   logic [C_CNT_W-1:0] cnt_q;
   logic               w_busy, w_progress;

   assign w_busy = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

   // Any handshake this cycle beats a simultaneous expiry.
   always_comb begin
      w_progress = 1'b0;
      case (state_q)
         ST_WR:      w_progress = w_aw_hs | w_w_hs;
         ST_WR_RESP: w_progress = w_b_hs;
         ST_RD_ADDR: w_progress = w_ar_hs;
         ST_RD_DATA: w_progress = w_r_hs;
         default:    w_progress = 1'b0;
      endcase
   end

   assign w_expire = w_busy & ~w_progress &
                     (cnt_q >= C_CNT_W'(P_TIMEOUT_CYCLES - 1));

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset || w_accept) begin
         cnt_q <= '0;
      end else if (w_busy) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         awaddr_q      <= '0;
         awvalid_q     <= 1'b0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         araddr_q      <= '0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= C_OKAY;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         awaddr_q      <= awaddr_d;
         awvalid_q     <= awvalid_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         araddr_q      <= araddr_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (w_accept) state_d = cmd_write ? ST_WR : ST_RD_ADDR;
         ST_WR:      if (w_wr_done) state_d = ST_WR_RESP;
                     else if (w_expire) state_d = ST_RSP;
         ST_WR_RESP: if (w_b_hs || w_expire) state_d = ST_RSP;
         ST_RD_ADDR: if (w_ar_hs) state_d = ST_RD_DATA;
                     else if (w_expire) state_d = ST_RSP;
         ST_RD_DATA: if (w_r_hs || w_expire) state_d = ST_RSP;
         ST_RSP:     if (w_rsp_hs) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_d   = cmd_ready_q;
      awaddr_d      = awaddr_q;
      awvalid_d     = awvalid_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      araddr_d      = araddr_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_write_d   = rsp_write_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;

      // Watchdog abort: every valid/ready drops, result reports DECERR.
      if (w_expire && !(state_q == ST_WR && w_wr_done)) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_write_d   = (state_q == ST_WR) || (state_q == ST_WR_RESP);
         rsp_rdata_d   = '0;
         rsp_resp_d    = C_DEC_ERR;
         rsp_timeout_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_accept) begin
                  cmd_ready_d = 1'b0;
                  if (cmd_write) begin
                     awaddr_d  = cmd_addr;
                     wdata_d   = cmd_wdata;
                     wstrb_d   = cmd_wstrb;
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                  end else begin
                     araddr_d  = cmd_addr;
                     arvalid_d = 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (w_aw_hs)   awvalid_d = 1'b0;
               if (w_w_hs)    wvalid_d  = 1'b0;
               if (w_wr_done) bready_d  = 1'b1;
            end
            ST_WR_RESP: begin
               if (w_b_hs) begin
                  bready_d      = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_write_d   = 1'b1;
                  rsp_rdata_d   = '0;
                  rsp_resp_d    = m_axi_bresp;
                  rsp_timeout_d = 1'b0;
               end
            end
            ST_RD_ADDR: begin
               if (w_ar_hs) begin
                  arvalid_d = 1'b0;
                  rready_d  = 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (w_r_hs) begin
                  rready_d      = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_write_d   = 1'b0;
                  rsp_rdata_d   = m_axi_rdata;
                  rsp_resp_d    = m_axi_rresp;
                  rsp_timeout_d = 1'b0;
               end
            end
            ST_RSP: begin
               if (w_rsp_hs) begin
                  rsp_valid_d = 1'b0;
                  cmd_ready_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_axil_master                                            |
// | Brief    : directed bench for axil_master with a configurable slave  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_axil_master;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid = 1'b0, bready;
   logic          arvalid, arready, rvalid = 1'b0, rready;
   logic [DW-1:0] wdata, rdata = '0;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp = 2'b00, rresp = 2'b00;

   always #5 clk = ~clk;

   axil_master #(
      .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_TIMEOUT_CYCLES(16)
   ) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready)
   );

   int errors = 0;
   int checks = 0;

   // Slave model: per-channel ready delay (-1 = never), optional B stall,
   // read data from memory unless an override is armed.
   int            aw_dly = 0, w_dly = 0, ar_dly = 0;
   bit            b_stall = 1'b0;
   logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit            rd_ovr_en = 1'b0;
   logic [DW-1:0] rd_ovr = '0;
   logic [DW-1:0] mem [0:511];
   int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
   int            n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   bit            got_aw = 1'b0, got_w = 1'b0;
   logic [AW-1:0] s_awaddr = '0;
   logic [DW-1:0] s_wdata = '0;

   assign awready = awvalid && (aw_dly >= 0) && (aw_cnt >= aw_dly);
   assign wready  = wvalid  && (w_dly  >= 0) && (w_cnt  >= w_dly);
   assign arready = arvalid && (ar_dly >= 0) && (ar_cnt >= ar_dly);

   wire            aw_hs  = awvalid & awready;
   wire            w_hs   = wvalid & wready;
   wire            aw_ok  = got_aw | aw_hs;
   wire            w_ok   = got_w | w_hs;
   wire [AW-1:0]   a_eff  = aw_hs ? awaddr : s_awaddr;
   wire [DW-1:0]   d_eff  = w_hs ? wdata : s_wdata;

   always @(posedge clk) begin
      if (rst) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         got_aw <= 1'b0; got_w <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (aw_hs) begin n_aw <= n_aw + 1; got_aw <= 1'b1; s_awaddr <= awaddr; end
         if (w_hs)  begin n_w <= n_w + 1; got_w <= 1'b1; s_wdata <= wdata; end
         if (aw_ok && w_ok && !bvalid && !b_stall) begin
            bvalid <= 1'b1;
            bresp  <= bresp_cfg;
            mem[a_eff[10:2]] <= d_eff;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
         end
         if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
         if (arvalid && arready) begin
            n_ar   <= n_ar + 1;
            rvalid <= 1'b1;
            rdata  <= rd_ovr_en ? rd_ovr : mem[araddr[10:2]];
            rresp  <= rresp_cfg;
         end
         if (rvalid && rready) begin rvalid <= 1'b0; n_r <= n_r + 1; end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and return just after the accepting edge.
   task automatic issue(input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
      int n;
      n = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      if (n >= 50) begin
         errors++;
         $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 100) begin tick(); lat++; end
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
      end
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_axi: aw/w/b/ar/r=%b, required 00000", {awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || wstrb !== '0) begin
         errors++;
         $display("FAIL reset_fields: awaddr=%h araddr=%h wdata=%h wstrb=%h, required 0", awaddr, araddr, wdata, wstrb);
      end
      checks++;
      if (rsp_rdata !== '0 || rsp_resp !== 2'b00 || rsp_write !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: rdata=%h resp=%b write=%b to=%b, required 0", rsp_rdata, rsp_resp, rsp_write, rsp_timeout);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      int lat;
      issue(1'b1, 11'h000, 32'hDEADBEEF, 4'hF);
      checks++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 11'h000 ||
          wdata !== 32'hDEADBEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
         errors++;
         $display("FAIL wr_issue: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h awprot=%b, required 1 1 000 deadbeef f 0",
                  awvalid, wvalid, awaddr, wdata, wstrb, awprot);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL wr_latency: %0d cycles, required 2", lat);
      end
      checks++;
      if (rsp_resp !== 2'b00 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wr_rsp: resp=%b write=%b rdata=%h to=%b, required 00 1 0 0", rsp_resp, rsp_write, rsp_rdata, rsp_timeout);
      end
      consume();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_consume: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
      end

      issue(1'b0, 11'h000, '0, '0);
      checks++;
      if (arvalid !== 1'b1 || araddr !== 11'h000 || arprot !== 3'b000 || awvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_issue: arv=%b araddr=%h arprot=%b awv=%b, required 1 000 0 0", arvalid, araddr, arprot, awvalid);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 2 || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
         errors++;
         $display("FAIL rd_rsp: lat=%0d rdata=%h resp=%b write=%b, required 2 deadbeef 00 0", lat, rsp_rdata, rsp_resp, rsp_write);
      end
      consume();

      // Top address, partial strobe; cmd fields are cleared right after accept.
      issue(1'b1, 11'h7FC, 32'h0000BEEF, 4'h3);
      tick();
      checks++;
      if (awaddr !== 11'h7FC || wstrb !== 4'h3 || wdata !== 32'h0000BEEF) begin
         errors++;
         $display("FAIL wr_capture: awaddr=%h wstrb=%h wdata=%h, required 7fc 3 0000beef", awaddr, wstrb, wdata);
      end
      wait_rsp(lat);
      consume();
   endtask

   task automatic test_w_before_aw();
      int lat, b0, aw0, w0;
      b0 = n_b; aw0 = n_aw; w0 = n_w;
      aw_dly = 3; w_dly = 0;
      issue(1'b1, 11'h008, 32'hA5A50001, 4'hF);
      tick();
      checks++;
      if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
         errors++;
         $display("FAIL split_w_first: wvalid=%b awvalid=%b, required 0 1", wvalid, awvalid);
      end
      tick(); tick();
      checks++;
      if (awvalid !== 1'b1 || awaddr !== 11'h008 || bready !== 1'b0) begin
         errors++;
         $display("FAIL split_aw_hold: awvalid=%b awaddr=%h bready=%b, required 1 008 0", awvalid, awaddr, bready);
      end
      tick();
      checks++;
      if (awvalid !== 1'b0 || bready !== 1'b1) begin
         errors++;
         $display("FAIL split_aw_done: awvalid=%b bready=%b, required 0 1", awvalid, bready);
      end
      wait_rsp(lat);
      checks++;
      if (rsp_resp !== 2'b00 || rsp_write !== 1'b1) begin
         errors++;
         $display("FAIL split_rsp: resp=%b write=%b, required 00 1", rsp_resp, rsp_write);
      end
      consume();
      repeat (3) tick();
      checks++;
      if (n_b - b0 != 1 || n_aw - aw0 != 1 || n_w - w0 != 1 || mem[2] !== 32'hA5A50001) begin
         errors++;
         $display("FAIL split_counts: b=%0d aw=%0d w=%0d mem=%h, required 1 1 1 a5a50001",
                  n_b - b0, n_aw - aw0, n_w - w0, mem[2]);
      end
      aw_dly = 0;
   endtask

   task automatic test_late_ready();
      int lat;
      aw_dly = 1; w_dly = 1;
      issue(1'b1, 11'h00C, 32'h0BADF00D, 4'hF);
      wait_rsp(lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL late_ready_latency: %0d cycles, required 3", lat);
      end
      consume();
      aw_dly = 0; w_dly = 0;
   endtask

   task automatic test_rd_err();
      int lat, ar0;
      ar0 = n_ar;
      rd_ovr_en = 1'b1; rd_ovr = 32'h12345678; rresp_cfg = 2'b10;
      issue(1'b0, 11'h010, '0, '0);
      wait_rsp(lat);
      checks++;
      if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h12345678 || rsp_write !== 1'b0) begin
         errors++;
         $display("FAIL rd_slverr: resp=%b rdata=%h write=%b, required 10 12345678 0", rsp_resp, rsp_rdata, rsp_write);
      end
      consume();
      repeat (5) tick();
      checks++;
      if (n_ar - ar0 != 1 || arvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_no_retry: ar_count=%0d arvalid=%b, required 1 0", n_ar - ar0, arvalid);
      end
      rresp_cfg = 2'b00; rd_ovr_en = 1'b0;
   endtask

   task automatic test_rsp_hold();
      int lat, aw0;
      aw0 = n_aw;
      rd_ovr_en = 1'b1; rd_ovr = 32'hCAFEF00D;
      issue(1'b0, 11'h018, '0, '0);
      wait_rsp(lat);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h01C; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || cmd_ready !== 1'b0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_hold[%0d]: rsp_valid=%b rdata=%h cmd_ready=%b awvalid=%b, required 1 cafef00d 0 0",
                     i, rsp_valid, rsp_rdata, cmd_ready, awvalid);
         end
      end
      cmd_valid = 1'b0; cmd_write = 1'b0;
      consume();
      tick();
      checks++;
      if (n_aw != aw0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rsp_hold_noaccept: aw_count=%0d cmd_ready=%b, required 0 1", n_aw - aw0, cmd_ready);
      end
      rd_ovr_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      b_stall = 1'b1;
      issue(1'b1, 11'h020, 32'h55AA55AA, 4'hF);
      tick();
      checks++;
      if (bready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: bready=%b, required 1", bready);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst: aw/w/b/ar/r=%b cmd_ready=%b rsp_valid=%b, required 00000 1 0",
                  {awvalid, wvalid, bready, arvalid, rready}, cmd_ready, rsp_valid);
      end
      rst = 1'b0;
      b_stall = 1'b0;
      tick();
      issue(1'b0, 11'h000, '0, '0);
      wait_rsp(lat);
      checks++;
      if (rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
         errors++;
         $display("FAIL midrst_recover: rdata=%h resp=%b, required deadbeef 00", rsp_rdata, rsp_resp);
      end
      consume();
   endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      int hi, ar0;
      ar0 = n_ar;
      ar_dly = -1;
      issue(1'b0, 11'h030, '0, '0);
      hi = 0;
      while (arvalid && hi < 40) begin hi++; tick(); end
      checks++;
      if (hi != 16) begin
         errors++;
         $display("FAIL to_arvalid_len: %0d cycles, required 16", hi);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || rready !== 1'b0) begin
         errors++;
         $display("FAIL to_rsp: valid=%b resp=%b to=%b rdata=%h rready=%b, required 1 11 1 0 0",
                  rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, rready);
      end
      consume();
      ar_dly = 0;
      checks++;
      if (n_ar != ar0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL to_after: ar_count=%0d cmd_ready=%b, required 0 1", n_ar - ar0, cmd_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_w_before_aw();
      test_late_ready();
      test_rd_err();
      test_rsp_hold();
      test_reset_mid();
`ifdef AXIL_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation exceeded time limit");
      $fatal(1, "global watchdog expired");
   end

endmodule
`default_nettype wire
